// File: rtl/ahb_output_stage_rr_if.sv
// Signal bundle for one bus-matrix output stage: the per-port request
// fields coming from the input stages and the muxed slave-side bus.
interface ahb_output_stage_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MASTER_W  = 4
);
  logic [NUM_PORTS-1:0]          sel_op;
  logic [NUM_PORTS-1:0]          held_tran_op;
  logic [NUM_PORTS*ADDR_W-1:0]   addr_op;
  logic [2*NUM_PORTS-1:0]        trans_op;
  logic [NUM_PORTS-1:0]          write_op;
  logic [3*NUM_PORTS-1:0]        size_op;
  logic [3*NUM_PORTS-1:0]        burst_op;
  logic [4*NUM_PORTS-1:0]        prot_op;
  logic [MASTER_W*NUM_PORTS-1:0] master_op;
  logic [NUM_PORTS-1:0]          mastlock_op;
  logic [DATA_W*NUM_PORTS-1:0]   wdata_op;
  logic [NUM_PORTS-1:0]          active_op;

  logic                          HSELM;
  logic [ADDR_W-1:0]             HADDRM;
  logic [1:0]                    HTRANSM;
  logic                          HWRITEM;
  logic [2:0]                    HSIZEM;
  logic [2:0]                    HBURSTM;
  logic [3:0]                    HPROTM;
  logic [MASTER_W-1:0]           HMASTERM;
  logic                          HMASTLOCKM;
  logic [DATA_W-1:0]             HWDATAM;
  logic                          HREADYOUTM;
  logic                          HREADYMUXM;

  modport slave (
    input  sel_op, held_tran_op, addr_op, trans_op, write_op, size_op,
           burst_op, prot_op, master_op, mastlock_op, wdata_op, HREADYOUTM,
    output active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
           HPROTM, HMASTERM, HMASTLOCKM, HWDATAM, HREADYMUXM
  );

  modport master (
    output sel_op, held_tran_op, addr_op, trans_op, write_op, size_op,
           burst_op, prot_op, master_op, mastlock_op, wdata_op, HREADYOUTM,
    input  active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
           HPROTM, HMASTERM, HMASTLOCKM, HWDATAM, HREADYMUXM
  );
endinterface

// File: rtl/ahb_output_stage_rr.sv
// AHB bus-matrix output stage: round-robin arbitration of input-stage
// requests for one slave, with grant held across locked sequences and
// fixed-length bursts, plus address/data muxing and HREADYMUXM generation.
module ahb_output_stage_rr #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MASTER_W  = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_output_stage_rr_if.slave bus
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  logic [PORT_W-1:0]    addr_port_q, addr_port_d;
  logic                 no_port_q, no_port_d;
  logic [PORT_W-1:0]    data_port_q, data_port_d;
  logic                 slave_sel_q, slave_sel_d;
  logic                 hsel_lock_q, hsel_lock_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;

  logic                 sel_m, write_m, lock_m;
  logic [ADDR_W-1:0]    addr_m;
  logic [1:0]           trans_m;
  logic [2:0]           size_m, burst_m;
  logic [3:0]           prot_m;
  logic [MASTER_W-1:0]  master_m;
  logic [NUM_PORTS-1:0] active_m;
  logic [DATA_W-1:0]    wdata_m;

  logic [NUM_PORTS-1:0] req;
  logic                 req_cur;
  logic                 hready_mux;
  logic                 hlock_arb;
  logic [3:0]           beat_next;
  logic                 upper_found, lower_found;
  logic [PORT_W-1:0]    upper_port, lower_port;

  assign req        = bus.held_tran_op & bus.sel_op;
  assign hready_mux = slave_sel_q ? bus.HREADYOUTM : 1'b1;
  assign hlock_arb  = lock_m & (hsel_lock_q | sel_m);

  // Route the granted port's address/control fields to the slave, or all zeros when idle
  always_comb begin
    sel_m    = 1'b0;
    write_m  = 1'b0;
    lock_m   = 1'b0;
    addr_m   = '0;
    trans_m  = '0;
    size_m   = '0;
    burst_m  = '0;
    prot_m   = '0;
    master_m = '0;
    active_m = '0;
    req_cur  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_port_q == PORT_W'(i)) begin
        req_cur = req[i];
        if (!no_port_q) begin
          sel_m       = bus.sel_op[i];
          write_m     = bus.write_op[i];
          lock_m      = bus.mastlock_op[i];
          addr_m      = bus.addr_op[i*ADDR_W +: ADDR_W];
          trans_m     = bus.trans_op[2*i +: 2];
          size_m      = bus.size_op[3*i +: 3];
          burst_m     = bus.burst_op[3*i +: 3];
          prot_m      = bus.prot_op[4*i +: 4];
          master_m    = bus.master_op[i*MASTER_W +: MASTER_W];
          active_m[i] = 1'b1;
        end
      end
    end
  end

  // Write data follows the port that owned the previous address phase
  always_comb begin
    wdata_m = bus.wdata_op[DATA_W-1:0];
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port_q == PORT_W'(i)) begin
        wdata_m = bus.wdata_op[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin search: lowest requester above the owner first, else the lowest at or below it
  always_comb begin
    upper_found = 1'b0;
    lower_found = 1'b0;
    upper_port  = '0;
    lower_port  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (PORT_W'(i) > addr_port_q) begin
          upper_found = 1'b1;
          upper_port  = PORT_W'(i);
        end else begin
          lower_found = 1'b1;
          lower_port  = PORT_W'(i);
        end
      end
    end
  end

  // Remaining burst beats once the current address phase completes
  always_comb begin
    beat_next = beat_cnt_q;
    if (sel_m && (trans_m == TRANS_NONSEQ)) begin
      case (burst_m)
        3'd2, 3'd3: beat_next = 4'd3;
        3'd4, 3'd5: beat_next = 4'd7;
        3'd6, 3'd7: beat_next = 4'd15;
        default:    beat_next = 4'd0;
      endcase
    end else if (sel_m && (trans_m == TRANS_SEQ)) begin
      if (beat_cnt_q != 4'd0) begin
        beat_next = beat_cnt_q - 4'd1;
      end
    end
  end

  // Grant, data-port and lock state advance only when the transfer completes
  always_comb begin
    addr_port_d = addr_port_q;
    no_port_d   = no_port_q;
    data_port_d = data_port_q;
    slave_sel_d = slave_sel_q;
    hsel_lock_d = hsel_lock_q;
    beat_cnt_d  = beat_cnt_q;
    if (hready_mux) begin
      slave_sel_d = sel_m;
      data_port_d = addr_port_q;
      if (sel_m && trans_m[1] && lock_m) begin
        hsel_lock_d = 1'b1;
      end else if (!lock_m) begin
        hsel_lock_d = 1'b0;
      end
      if (hlock_arb) begin
        addr_port_d = addr_port_q;
      end else if ((beat_next != 4'd0) && req_cur) begin
        addr_port_d = addr_port_q;
      end else if (upper_found) begin
        addr_port_d = upper_port;
        no_port_d   = 1'b0;
      end else if (lower_found) begin
        addr_port_d = lower_port;
        no_port_d   = 1'b0;
      end else begin
        no_port_d   = 1'b1;
      end
      if ((addr_port_d != addr_port_q) || (no_port_d != no_port_q) || !req_cur) begin
        beat_cnt_d = 4'd0;
      end else begin
        beat_cnt_d = beat_next;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_port_q <= '0;
      no_port_q   <= 1'b1;
      data_port_q <= '0;
      slave_sel_q <= 1'b0;
      hsel_lock_q <= 1'b0;
      beat_cnt_q  <= 4'd0;
    end else begin
      addr_port_q <= addr_port_d;
      no_port_q   <= no_port_d;
      data_port_q <= data_port_d;
      slave_sel_q <= slave_sel_d;
      hsel_lock_q <= hsel_lock_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign bus.active_op  = active_m;
  assign bus.HSELM      = sel_m;
  assign bus.HADDRM     = addr_m;
  assign bus.HTRANSM    = trans_m;
  assign bus.HWRITEM    = write_m;
  assign bus.HSIZEM     = size_m;
  assign bus.HBURSTM    = burst_m;
  assign bus.HPROTM     = prot_m;
  assign bus.HMASTERM   = master_m;
  assign bus.HMASTLOCKM = lock_m;
  assign bus.HWDATAM    = wdata_m;
  assign bus.HREADYMUXM = hready_mux;
endmodule

// File: tb/tb_ahb_output_stage_rr.sv
// Directed self-checking bench for the round-robin AHB output stage.
module tb_ahb_output_stage_rr;
  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MASTER_W  = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;

  logic HCLK = 1'b0;
  logic HRESET;
  int   checkCount = 0;
  int   failCount  = 0;

  logic [3:0] rrAct   [6];
  int         rrData  [6];
  logic [1:0] burstTr [5];
  logic [3:0] burstAct[5];
  logic [1:0] busyTr  [7];
  logic [3:0] busyAct [7];

  ahb_output_stage_rr_if #(
    .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASTER_W(MASTER_W)
  ) bus ();

  ahb_output_stage_rr #(
    .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASTER_W(MASTER_W)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [ADDR_W-1:0] portAddr(input int p);
    return ADDR_W'(32'h1000_0000 + 32'(p) * 32'h100);
  endfunction

  function automatic logic [DATA_W-1:0] portData(input int p);
    return DATA_W'(32'hD000_0000 + 32'(p));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int p, input logic sel, input logic held,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic lock, input logic write);
    bus.sel_op[p]            = sel;
    bus.held_tran_op[p]      = held;
    bus.trans_op[2*p +: 2]   = trans;
    bus.burst_op[3*p +: 3]   = burst;
    bus.mastlock_op[p]       = lock;
    bus.write_op[p]          = write;
  endtask

  task automatic clearPorts();
    for (int p = 0; p < NUM_PORTS; p++) begin
      applyStimulus(p, 1'b0, 1'b0, IDLE, SINGLE, 1'b0, 1'b0);
    end
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #2;
  endtask

  task automatic doReset();
    clearPorts();
    bus.HREADYOUTM = 1'b1;
    HRESET = 1'b1;
    nextCycle();
    nextCycle();
    HRESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRESET = 1'b1;
    bus.HREADYOUTM = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.addr_op[p*ADDR_W +: ADDR_W]       = portAddr(p);
      bus.wdata_op[p*DATA_W +: DATA_W]      = portData(p);
      bus.master_op[p*MASTER_W +: MASTER_W] = MASTER_W'(p + 5);
      bus.size_op[3*p +: 3]                 = 3'd2;
      bus.prot_op[4*p +: 4]                 = 4'd3;
    end
    clearPorts();

    rrAct    = '{4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
    rrData   = '{0, 2, 3, 0, 2, 3};
    burstTr  = '{NONSEQ, SEQ, SEQ, SEQ, IDLE};
    burstAct = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    busyTr   = '{NONSEQ, BUSY, BUSY, SEQ, SEQ, SEQ, IDLE};
    busyAct  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};

    // Reset with every port requesting; first grant goes to port 1
    for (int p = 0; p < NUM_PORTS; p++) begin
      applyStimulus(p, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    end
    nextCycle();
    nextCycle();
    #1;
    checkOutput("rst_active", 64'(bus.active_op), 64'(4'b0000));
    checkOutput("rst_hsel", 64'(bus.HSELM), 64'(1'b0));
    checkOutput("rst_haddr", 64'(bus.HADDRM), 64'(32'h0));
    checkOutput("rst_hready", 64'(bus.HREADYMUXM), 64'(1'b1));
    checkOutput("rst_hwdata", 64'(bus.HWDATAM), 64'(portData(0)));
    HRESET = 1'b0;
    nextCycle();
    #1;
    checkOutput("first_grant", 64'(bus.active_op), 64'(4'b0010));
    checkOutput("first_haddr", 64'(bus.HADDRM), 64'(portAddr(1)));
    checkOutput("first_hmaster", 64'(bus.HMASTERM), 64'(4'd6));
    checkOutput("first_htrans", 64'(bus.HTRANSM), 64'(NONSEQ));

    // Round robin across ports 0, 2 and 3
    doReset();
    applyStimulus(0, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    applyStimulus(3, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      #1;
      checkOutput($sformatf("rr_grant%0d", k), 64'(bus.active_op), 64'(rrAct[k]));
      checkOutput($sformatf("rr_wdata%0d", k), 64'(bus.HWDATAM), 64'(portData(rrData[k])));
    end

    // INCR4 burst on port 1 holds the grant for four beats
    doReset();
    applyStimulus(0, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, NONSEQ, INCR4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      applyStimulus(1, 1'b1, burstTr[k] != IDLE, burstTr[k], INCR4, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("burst_beat%0d", k + 1), 64'(bus.active_op), 64'(burstAct[k]));
    end

    // Same burst with two BUSY cycles inserted
    doReset();
    applyStimulus(0, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, NONSEQ, INCR4, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      nextCycle();
      applyStimulus(1, 1'b1, busyTr[k] != IDLE, busyTr[k], INCR4, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("busy_cycle%0d", k), 64'(bus.active_op), 64'(busyAct[k]));
    end

    // Locked sequence on port 2 survives a one-cycle HSEL drop
    doReset();
    applyStimulus(2, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b1, 1'b0);
    applyStimulus(3, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    nextCycle();
    #1;
    checkOutput("lock_grant", 64'(bus.active_op), 64'(4'b0100));
    checkOutput("lock_hmastlock", 64'(bus.HMASTLOCKM), 64'(1'b1));
    nextCycle();
    applyStimulus(2, 1'b0, 1'b1, NONSEQ, SINGLE, 1'b1, 1'b0);
    #1;
    checkOutput("lock_hold", 64'(bus.active_op), 64'(4'b0100));
    checkOutput("lock_hsel_drop", 64'(bus.HSELM), 64'(1'b0));
    nextCycle();
    applyStimulus(2, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b1, 1'b0);
    #1;
    checkOutput("lock_after_drop", 64'(bus.active_op), 64'(4'b0100));
    nextCycle();
    applyStimulus(2, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    #1;
    checkOutput("lock_last", 64'(bus.active_op), 64'(4'b0100));
    nextCycle();
    #1;
    checkOutput("lock_release", 64'(bus.active_op), 64'(4'b1000));

    // Slave wait states freeze grant and data phase
    doReset();
    applyStimulus(2, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b1);
    applyStimulus(3, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b1);
    nextCycle();
    #1;
    checkOutput("wait_grant", 64'(bus.active_op), 64'(4'b0100));
    checkOutput("wait_hwrite", 64'(bus.HWRITEM), 64'(1'b1));
    nextCycle();
    bus.HREADYOUTM = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) nextCycle();
      #1;
      checkOutput($sformatf("wait_hready%0d", k), 64'(bus.HREADYMUXM), 64'(1'b0));
      checkOutput($sformatf("wait_active%0d", k), 64'(bus.active_op), 64'(4'b1000));
      checkOutput($sformatf("wait_hwdata%0d", k), 64'(bus.HWDATAM), 64'(portData(2)));
    end
    nextCycle();
    bus.HREADYOUTM = 1'b1;
    #1;
    checkOutput("wait_release_ready", 64'(bus.HREADYMUXM), 64'(1'b1));
    checkOutput("wait_release_active", 64'(bus.active_op), 64'(4'b1000));
    nextCycle();
    #1;
    checkOutput("wait_next_grant", 64'(bus.active_op), 64'(4'b0100));
    checkOutput("wait_next_hwdata", 64'(bus.HWDATAM), 64'(portData(3)));

    // Reset in the middle of an INCR8 burst
    doReset();
    applyStimulus(0, 1'b1, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, NONSEQ, INCR8, 1'b0, 1'b0);
    nextCycle();
    #1;
    checkOutput("rstburst_beat1", 64'(bus.active_op), 64'(4'b0010));
    checkOutput("rstburst_hburst", 64'(bus.HBURSTM), 64'(INCR8));
    nextCycle();
    applyStimulus(1, 1'b1, 1'b1, SEQ, INCR8, 1'b0, 1'b0);
    HRESET = 1'b1;
    #1;
    checkOutput("rstburst_beat2", 64'(bus.active_op), 64'(4'b0010));
    nextCycle();
    HRESET = 1'b0;
    #1;
    checkOutput("rstburst_active", 64'(bus.active_op), 64'(4'b0000));
    checkOutput("rstburst_hready", 64'(bus.HREADYMUXM), 64'(1'b1));
    checkOutput("rstburst_hsel", 64'(bus.HSELM), 64'(1'b0));
    nextCycle();
    #1;
    checkOutput("rstburst_regrant", 64'(bus.active_op), 64'(4'b0010));
    nextCycle();
    #1;
    checkOutput("rstburst_no_hold", 64'(bus.active_op), 64'(4'b0001));

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
